// File: rtl/i2c_target_mem.sv
// I2C target exposing a Depth-byte memory plus a local system-side port; optional input glitch filter under I2C_TARGET_FILTER_EN.
// Latency: pin to edge detect 2 cycles (2+FilterCycles filtered); sda_en_o updates 1 cycle after a detected SCL fall.
// No backpressure: SCL is never stretched, every written byte is ACKed, and the local port is always accepted.
module i2c_target_mem #(
  parameter logic [6:0]  TargetAddr   = 7'h50,
  parameter int unsigned Depth        = 16,
  parameter int unsigned FilterCycles = 4
) (
  input  logic                     clk_sys_i,
  input  logic                     rst_sys_ni,
  input  logic                     scl_i,
  input  logic                     sda_i,
  output logic                     sda_o,
  output logic                     sda_en_o,
  input  logic                     loc_we_i,
  input  logic [$clog2(Depth)-1:0] loc_addr_i,
  input  logic [7:0]               loc_wdata_i,
  output logic [7:0]               loc_rdata_o,
  output logic                     i2c_wr_o,
  output logic [$clog2(Depth)-1:0] i2c_wr_addr_o,
  output logic                     busy_o
);
  localparam int unsigned AW = $clog2(Depth);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] ADDR      = 3'd1;
  localparam logic [2:0] ADDR_ACK  = 3'd2;
  localparam logic [2:0] WR_BYTE   = 3'd3;
  localparam logic [2:0] WR_ACK    = 3'd4;
  localparam logic [2:0] RD_BYTE   = 3'd5;
  localparam logic [2:0] RD_ACK    = 3'd6;
  localparam logic [2:0] WAIT_STOP = 3'd7;

  // Pin vectors: bit 1 = SCL, bit 0 = SDA.
  logic [1:0] pin_s1_q, pin_s1_d, pin_s2_q, pin_s2_d, pin_p_q, pin_p_d, pin_c;

  logic [2:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [7:0]    sh_q, sh_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          rw_q, rw_d;
  logic          first_q, first_d;
  logic          sda_en_q, sda_en_d;
  logic          busy_q, busy_d;
  logic          wr_q, wr_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;

  logic [7:0] mem [Depth];
  logic [7:0] rx_byte, rd_word;
  logic       commit;
  logic       scl_c, sda_c, scl_p, sda_p;
  logic       scl_rise, scl_fall, start_det, stop_det;

  assign pin_s1_d = {scl_i, sda_i};
  assign pin_s2_d = pin_s1_q;
  assign pin_p_d  = pin_c;

`ifdef I2C_TARGET_FILTER_EN
  localparam int unsigned FW = (FilterCycles > 1) ? $clog2(FilterCycles) : 1;

  logic [1:0]         filt_q, filt_d;
  logic [1:0][FW-1:0] fcnt_q, fcnt_d;

  // A level change is accepted only after FilterCycles consecutive differing samples.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = fcnt_q;
    for (int i = 0; i < 2; i++) begin
      if (pin_s2_q[i] == filt_q[i]) begin
        fcnt_d[i] = '0;
      end else if (fcnt_q[i] == FW'(FilterCycles - 1)) begin
        filt_d[i] = pin_s2_q[i];
        fcnt_d[i] = '0;
      end else begin
        fcnt_d[i] = fcnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      filt_q <= 2'b11;
      fcnt_q <= '0;
    end else begin
      filt_q <= filt_d;
      fcnt_q <= fcnt_d;
    end
  end

  assign pin_c = filt_q;
`else
  assign pin_c = pin_s2_q;
`endif

  assign scl_c     = pin_c[1];
  assign sda_c     = pin_c[0];
  assign scl_p     = pin_p_q[1];
  assign sda_p     = pin_p_q[0];
  assign scl_rise  = scl_c & ~scl_p;
  assign scl_fall  = ~scl_c & scl_p;
  assign start_det = scl_c & scl_p & sda_p & ~sda_c;
  assign stop_det  = scl_c & scl_p & ~sda_p & sda_c;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    ptr_d     = ptr_q;
    rw_d      = rw_q;
    first_d   = first_q;
    sda_en_d  = sda_en_q;
    busy_d    = busy_q;
    wr_d      = 1'b0;
    wr_addr_d = wr_addr_q;
    commit    = 1'b0;
    rx_byte   = {sh_q[6:0], sda_c};
    rd_word   = mem[ptr_q];

    if (stop_det) begin
      state_d  = IDLE;
      cnt_d    = '0;
      sda_en_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start_det) begin
      state_d  = ADDR;
      cnt_d    = '0;
      sda_en_d = 1'b0;
    end else begin
      unique case (state_q)
        ADDR: begin
          if (scl_rise) begin
            sh_d = rx_byte;
            if (cnt_q == 4'd7) begin
              cnt_d = '0;
              if (rx_byte[7:1] == TargetAddr) begin
                state_d = ADDR_ACK;
                rw_d    = rx_byte[0];
                busy_d  = 1'b1;
              end else begin
                state_d = WAIT_STOP;
              end
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end
        end
        // The first fall in an ACK state opens the 9th clock (drive ACK); the second closes it.
        ADDR_ACK, WR_ACK: begin
          if (scl_fall) begin
            if (!sda_en_q) begin
              sda_en_d = 1'b1;
            end else begin
              sda_en_d = 1'b0;
              cnt_d    = '0;
              if (state_q == ADDR_ACK && rw_q) begin
                state_d  = RD_BYTE;
                sh_d     = rd_word;
                sda_en_d = ~rd_word[7];
              end else begin
                state_d = WR_BYTE;
                if (state_q == ADDR_ACK) first_d = 1'b1;
              end
            end
          end
        end
        WR_BYTE: begin
          if (scl_rise) begin
            sh_d = rx_byte;
            if (cnt_q == 4'd7) begin
              cnt_d   = '0;
              state_d = WR_ACK;
              if (first_q) begin
                ptr_d   = rx_byte[AW-1:0];
                first_d = 1'b0;
              end else begin
                commit    = 1'b1;
                wr_d      = 1'b1;
                wr_addr_d = ptr_q;
                ptr_d     = ptr_q + 1'b1;
              end
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end
        end
        RD_BYTE: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              state_d  = RD_ACK;
              cnt_d    = '0;
              sda_en_d = 1'b0;
              ptr_d    = ptr_q + 1'b1;
            end else begin
              sh_d     = {sh_q[6:0], 1'b1};
              sda_en_d = ~sh_q[6];
            end
          end
        end
        RD_ACK: begin
          if (scl_rise && sda_c) begin
            state_d = WAIT_STOP;
          end else if (scl_fall) begin
            state_d  = RD_BYTE;
            sh_d     = rd_word;
            sda_en_d = ~rd_word[7];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      pin_s1_q  <= 2'b11;
      pin_s2_q  <= 2'b11;
      pin_p_q   <= 2'b11;
      state_q   <= IDLE;
      cnt_q     <= '0;
      sh_q      <= '0;
      ptr_q     <= '0;
      rw_q      <= 1'b0;
      first_q   <= 1'b0;
      sda_en_q  <= 1'b0;
      busy_q    <= 1'b0;
      wr_q      <= 1'b0;
      wr_addr_q <= '0;
    end else begin
      pin_s1_q  <= pin_s1_d;
      pin_s2_q  <= pin_s2_d;
      pin_p_q   <= pin_p_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sh_q      <= sh_d;
      ptr_q     <= ptr_d;
      rw_q      <= rw_d;
      first_q   <= first_d;
      sda_en_q  <= sda_en_d;
      busy_q    <= busy_d;
      wr_q      <= wr_d;
      wr_addr_q <= wr_addr_d;
    end
  end

  // Local write is issued last so it overrides an I2C commit to the same address.
  always_ff @(posedge clk_sys_i) begin
    if (commit) mem[ptr_q] <= rx_byte;
    if (loc_we_i) mem[loc_addr_i] <= loc_wdata_i;
  end

  assign sda_o         = 1'b0;
  assign sda_en_o      = sda_en_q;
  assign loc_rdata_o   = mem[loc_addr_i];
  assign i2c_wr_o      = wr_q;
  assign i2c_wr_addr_o = wr_addr_q;
  assign busy_o        = busy_q;
endmodule

// File: tb/tb_i2c_target_mem.sv
// Bench for i2c_target_mem: bit-banged I2C controller, byte-memory model, write/read scoreboards.
module tb_i2c_target_mem;
  localparam int Q = 4;

  logic       clk_sys = 1'b0;
  logic       rst_n, scl_drv, sda_drv, sda_bus;
  logic       sda_o, sda_en_o, i2c_wr_o, busy_o, loc_we;
  logic [3:0] loc_addr, wr_addr;
  logic [7:0] loc_wdata, loc_rdata;

  int         checks = 0;
  int         failures = 0;
  int         wr_exp_q[$];
  logic [7:0] rd_exp_q[$];
  logic [7:0] model [16];
  logic [3:0] mptr;
  logic       wr_prev = 1'b0;
  logic       seen_en, seen_busy;
  logic       a;
  logic [7:0] got, glitch_exp;

  always #5 clk_sys = ~clk_sys;
  assign sda_bus = sda_drv & ~sda_en_o;

  i2c_target_mem #(.TargetAddr(7'h50), .Depth(16), .FilterCycles(4)) dut (
    .clk_sys_i(clk_sys), .rst_sys_ni(rst_n), .scl_i(scl_drv), .sda_i(sda_bus),
    .sda_o(sda_o), .sda_en_o(sda_en_o), .loc_we_i(loc_we), .loc_addr_i(loc_addr),
    .loc_wdata_i(loc_wdata), .loc_rdata_o(loc_rdata), .i2c_wr_o(i2c_wr_o),
    .i2c_wr_addr_o(wr_addr), .busy_o(busy_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic bus_start();
    sda_drv = 1'b1; wclk(Q); scl_drv = 1'b1; wclk(Q);
    sda_drv = 1'b0; wclk(Q); scl_drv = 1'b0;
  endtask

  task automatic bus_stop();
    wclk(Q); sda_drv = 1'b0; wclk(Q); scl_drv = 1'b1; wclk(Q);
    sda_drv = 1'b1; wclk(Q);
  endtask

  // One SCL period; optional 2-cycle low glitch in the high phase.
  task automatic clock_bit(input logic b, input logic glitch, output logic r);
    wclk(Q); sda_drv = b; wclk(Q); scl_drv = 1'b1;
    if (glitch) begin
      wclk(1); scl_drv = 1'b0; wclk(2); scl_drv = 1'b1; wclk(1);
    end else begin
      wclk(Q);
    end
    r = sda_bus; wclk(Q); scl_drv = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] b, input int gbit, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], i == gbit, r);
    clock_bit(1'b1, 1'b0, ack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] b);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, 1'b0, r);
      b[i] = r;
    end
    clock_bit(nack, 1'b0, r);
  endtask

  task automatic send_ack(input string tag, input logic [7:0] b);
    logic ack;
    write_byte(b, -1, ack);
    check(tag, 32'(ack), 0);
  endtask

  task automatic set_ptr(input logic [7:0] b);
    send_ack("ptr_ack", b);
    mptr = b[3:0];
  endtask

  task automatic send_data(input logic [7:0] b);
    wr_exp_q.push_back(int'(mptr));
    model[mptr] = b;
    mptr = mptr + 4'd1;
    send_ack("data_ack", b);
  endtask

  task automatic read_exp(input logic nack);
    logic [7:0] d;
    rd_exp_q.push_back(model[mptr]);
    mptr = mptr + 4'd1;
    read_byte(nack, d);
    check("rd_data", 32'(d), 32'(rd_exp_q.pop_front()));
  endtask

  task automatic check_mem(input int adr);
    loc_addr = 4'(adr);
    #1;
    check($sformatf("mem[%0d]", adr), 32'(loc_rdata), 32'(model[adr]));
  endtask

  always @(negedge clk_sys) begin
    if (i2c_wr_o) begin
      check("wr_pulse_expected", 32'(wr_exp_q.size() != 0), 1);
      if (wr_exp_q.size() != 0) check("wr_addr", 32'(wr_addr), 32'(wr_exp_q.pop_front()));
      check("wr_width", 32'(wr_prev), 0);
    end
    wr_prev = i2c_wr_o;
    if (sda_en_o) seen_en = 1'b1;
    if (busy_o) seen_busy = 1'b1;
  end

  initial begin
    #600000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; scl_drv = 1'b1; sda_drv = 1'b1;
    loc_we = 1'b0; loc_addr = '0; loc_wdata = '0; mptr = '0;
    wclk(5);
    check("rst_sda_en", 32'(sda_en_o), 0);
    check("rst_sda_o", 32'(sda_o), 0);
    check("rst_wr", 32'(i2c_wr_o), 0);
    check("rst_wr_addr", 32'(wr_addr), 0);
    check("rst_busy", 32'(busy_o), 0);
    rst_n = 1'b1;
    wclk(4);

    for (int k = 0; k < 16; k++) begin
      model[k] = 8'h80 + 8'(k);
      loc_addr = 4'(k); loc_wdata = model[k]; loc_we = 1'b1;
      wclk(1);
    end
    loc_we = 1'b0;
    check_mem(7);

    // Write 0xA5, 0x5A from pointer 3.
    bus_start(); send_ack("addr_w", 8'hA0);
    check("busy_after_match", 32'(busy_o), 1);
    set_ptr(8'h03); send_data(8'hA5); send_data(8'h5A);
    bus_stop();
    check("busy_after_stop", 32'(busy_o), 0);
    check_mem(3); check_mem(4);

    // Pointer write, repeated start, read ACK then NACK.
    bus_start(); send_ack("addr_w", 8'hA0); set_ptr(8'h03);
    bus_start(); send_ack("addr_r", 8'hA1);
    read_exp(1'b0); read_exp(1'b1);
    wclk(Q);
    check("rd_release_after_nack", 32'(sda_en_o), 0);
    check("busy_in_wait_stop", 32'(busy_o), 1);
    bus_stop();
    bus_start(); send_ack("addr_r", 8'hA1); read_exp(1'b1); bus_stop();

    // Address mismatch: never drive, never busy.
    seen_en = 1'b0; seen_busy = 1'b0;
    bus_start();
    write_byte(8'hA2, -1, a); check("mm_addr_nack", 32'(a), 1);
    write_byte(8'hFF, -1, a); check("mm_data_nack", 32'(a), 1);
    bus_stop();
    check("mm_sda_en_seen", 32'(seen_en), 0);
    check("mm_busy_seen", 32'(seen_busy), 0);

    // Pointer wrap, then a pointer byte with ignored upper bits.
    bus_start(); send_ack("addr_w", 8'hA0); set_ptr(8'h0F);
    send_data(8'h11); send_data(8'h22); send_data(8'h33); bus_stop();
    check_mem(15); check_mem(0); check_mem(1);
    bus_start(); send_ack("addr_w", 8'hA0); set_ptr(8'hF4); bus_stop();
    bus_start(); send_ack("addr_r", 8'hA1); read_exp(1'b1); bus_stop();

    // Local write in the i2c_wr_o cycle for the same address.
    bus_start(); send_ack("addr_w", 8'hA0); set_ptr(8'h03);
    fork
      send_data(8'h12);
      begin
        int k;
        k = 0;
        while (k < 400 && !i2c_wr_o) begin
          wclk(1);
          k++;
        end
        check("coll_pulse_seen", 32'(i2c_wr_o), 1);
        loc_addr = 4'd3; loc_wdata = 8'h77; loc_we = 1'b1;
        wclk(1);
        loc_we = 1'b0;
      end
    join
    bus_stop();
    model[3] = 8'h77;
    check_mem(3);

    // STOP after 4 data bits: no write, pointer unchanged.
    bus_start(); send_ack("addr_w", 8'hA0); set_ptr(8'h06);
    for (int i = 0; i < 4; i++) clock_bit(1'b0, 1'b0, a);
    bus_stop();
    check("abort_idle", 32'(busy_o), 0);
    check_mem(6);
    bus_start(); send_ack("addr_r", 8'hA1); read_exp(1'b1); bus_stop();

    // SCL glitch during bit 4 of 0x3C: unfiltered it duplicates that bit.
`ifdef I2C_TARGET_FILTER_EN
    glitch_exp = 8'h3C;
`else
    glitch_exp = 8'h3E;
`endif
    bus_start(); send_ack("addr_w", 8'hA0); set_ptr(8'h08);
    wr_exp_q.push_back(int'(mptr));
    model[mptr] = glitch_exp;
    mptr = mptr + 4'd1;
    write_byte(8'h3C, 4, a);
    bus_stop();
    check_mem(8);

    // Reset while driving the address ACK releases SDA at once and clears the pointer.
    bus_start();
    for (int i = 7; i >= 0; i--) clock_bit(((8'hA0 >> i) & 8'h01) != 0, 1'b0, a);
    wclk(Q);
    check("ack_driven", 32'(sda_en_o), 1);
    rst_n = 1'b0;
    #1;
    check("rst_async_release", 32'(sda_en_o), 0);
    wclk(2); rst_n = 1'b1; mptr = '0;
    wclk(Q); scl_drv = 1'b1; wclk(2 * Q); scl_drv = 1'b0;
    bus_stop();
    check("rst_busy_clear", 32'(busy_o), 0);
    bus_start(); send_ack("addr_r", 8'hA1); read_exp(1'b1); bus_stop();

    wclk(4);
    check("wr_queue_drained", 32'(wr_exp_q.size()), 0);
    check("rd_queue_drained", 32'(rd_exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
